// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the generator and the downstream stage
interface vga_timing_gen_if;
    logic        CE;
    logic [11:0] HORIZONTAL;
    logic [11:0] VERTICAL;
    logic        HSYNC;
    logic        VSYNC;
    logic        LINE_END;
    logic        FRAME_END;
    logic [7:0]  FRAME_CNT;

    modport master (
        input  CE,
        output HORIZONTAL,
        output VERTICAL,
        output HSYNC,
        output VSYNC,
        output LINE_END,
        output FRAME_END,
        output FRAME_CNT
    );

    modport slave (
        output CE,
        input  HORIZONTAL,
        input  VERTICAL,
        input  HSYNC,
        input  VSYNC,
        input  LINE_END,
        input  FRAME_END,
        input  FRAME_CNT
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running raster counters with syncs, strobes and frame counter
module vga_timing_gen #(
    parameter int H_RES  = 1024,
    parameter int H_FP   = 24,
    parameter int H_SYNC = 136,
    parameter int H_BP   = 160,
    parameter int V_RES  = 768,
    parameter int V_FP   = 3,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 29,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic              PIX_CLK,
    input  logic              RST,
    vga_timing_gen_if.master  vif
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Totals may reach 4096, so only the last index is narrowed to 12 bits.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_FIRST = 12'(H_RES + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_RES + V_FP);
    localparam logic [11:0] VS_LAST  = 12'(V_RES + V_FP + V_SYNC - 1);

    logic [11:0] horizontal_q, horizontal_d;
    logic [11:0] vertical_q,   vertical_d;
    logic        hsync_q,      hsync_d;
    logic        vsync_q,      vsync_d;
    logic        line_end_q,   line_end_d;
    logic        frame_end_q,  frame_end_d;
    logic [7:0]  frame_cnt_q,  frame_cnt_d;

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (horizontal_q == H_LAST);
    assign v_wrap = (vertical_q == V_LAST);

    always_comb begin
        horizontal_d = horizontal_q;
        vertical_d   = vertical_q;
        frame_cnt_d  = frame_cnt_q;

        if (vif.CE) begin
            if (h_wrap) begin
                horizontal_d = 12'd0;
                if (v_wrap) begin
                    vertical_d  = 12'd0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    vertical_d  = vertical_q + 12'd1;
                end
            end else begin
                horizontal_d = horizontal_q + 12'd1;
            end
        end
    end

    // Decoding the next counter values keeps syncs and strobes aligned with the counters.
    always_comb begin
        hsync_d     = ~H_POL;
        vsync_d     = ~V_POL;
        line_end_d  = 1'b0;
        frame_end_d = 1'b0;

        if ((horizontal_d >= HS_FIRST) && (horizontal_d <= HS_LAST)) begin
            hsync_d = H_POL;
        end
        if ((vertical_d >= VS_FIRST) && (vertical_d <= VS_LAST)) begin
            vsync_d = V_POL;
        end
        if (horizontal_d == H_LAST) begin
            line_end_d = 1'b1;
            if (vertical_d == V_LAST) begin
                frame_end_d = 1'b1;
            end
        end
    end

    always_ff @(posedge PIX_CLK) begin
        if (RST) begin
            horizontal_q <= 12'd0;
            vertical_q   <= 12'd0;
            hsync_q      <= ~H_POL;
            vsync_q      <= ~V_POL;
            line_end_q   <= 1'b0;
            frame_end_q  <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            horizontal_q <= horizontal_d;
            vertical_q   <= vertical_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            line_end_q   <= line_end_d;
            frame_end_q  <= frame_end_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign vif.HORIZONTAL = horizontal_q;
    assign vif.VERTICAL   = vertical_q;
    assign vif.HSYNC      = hsync_q;
    assign vif.VSYNC      = vsync_q;
    assign vif.LINE_END   = line_end_q;
    assign vif.FRAME_END  = frame_end_q;
    assign vif.FRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for default, small and inverted-polarity timing generators
module tb_vga_timing_gen;

    logic PIX_CLK = 1'b0;
    logic RST     = 1'b1;

    always #5 PIX_CLK = ~PIX_CLK;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sml ();
    vga_timing_gen_if if_pol ();

    vga_timing_gen u_def (
        .PIX_CLK (PIX_CLK),
        .RST     (RST),
        .vif     (if_def)
    );

    vga_timing_gen #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_sml (
        .PIX_CLK (PIX_CLK),
        .RST     (RST),
        .vif     (if_sml)
    );

    vga_timing_gen #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_pol (
        .PIX_CLK (PIX_CLK),
        .RST     (RST),
        .vif     (if_pol)
    );

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        vs;
        logic        le;
        logic        fe;
        logic [7:0]  fc;
    } obs_t;

    obs_t q_def[$];
    obs_t q_sml[$];
    obs_t q_pol[$];
    obs_t cur_def, cur_sml, cur_pol, exp_o;

    int dh, dv, dfc;
    int sh, sv, sfc;
    int n_err = 0;
    int n_chk = 0;

    function automatic obs_t mk(input int h, input int v, input int fc,
                                input int hs0, input int hs1, input int vs0, input int vs1,
                                input int hl, input int vl, input logic hp, input logic vp);
        obs_t o;
        o.h  = 12'(h);
        o.v  = 12'(v);
        o.hs = (h >= hs0 && h <= hs1) ? hp : ~hp;
        o.vs = (v >= vs0 && v <= vs1) ? vp : ~vp;
        o.le = (h == hl);
        o.fe = (h == hl) && (v == vl);
        o.fc = 8'(fc);
        return o;
    endfunction

    task automatic cycle(input logic rst_i, input logic ce_i);
        RST = rst_i;
        if_def.CE = ce_i;
        if_sml.CE = ce_i;
        if_pol.CE = ce_i;
        if (rst_i) begin
            dh = 0; dv = 0; dfc = 0;
            sh = 0; sv = 0; sfc = 0;
        end else if (ce_i) begin
            if (dh == 1343) begin
                dh = 0;
                if (dv == 805) begin dv = 0; dfc = (dfc + 1) % 256; end
                else dv = dv + 1;
            end else dh = dh + 1;
            if (sh == 15) begin
                sh = 0;
                if (sv == 7) begin sv = 0; sfc = (sfc + 1) % 256; end
                else sv = sv + 1;
            end else sh = sh + 1;
        end
        q_def.push_back(mk(dh, dv, dfc, 1048, 1183, 771, 776, 1343, 805, 1'b0, 1'b0));
        q_sml.push_back(mk(sh, sv, sfc, 10, 12, 5, 6, 15, 7, 1'b0, 1'b0));
        q_pol.push_back(mk(sh, sv, sfc, 10, 12, 5, 6, 15, 7, 1'b1, 1'b1));
        @(posedge PIX_CLK);
        #1;
        cur_def = {if_def.HORIZONTAL, if_def.VERTICAL, if_def.HSYNC, if_def.VSYNC,
                   if_def.LINE_END, if_def.FRAME_END, if_def.FRAME_CNT};
        cur_sml = {if_sml.HORIZONTAL, if_sml.VERTICAL, if_sml.HSYNC, if_sml.VSYNC,
                   if_sml.LINE_END, if_sml.FRAME_END, if_sml.FRAME_CNT};
        cur_pol = {if_pol.HORIZONTAL, if_pol.VERTICAL, if_pol.HSYNC, if_pol.VSYNC,
                   if_pol.LINE_END, if_pol.FRAME_END, if_pol.FRAME_CNT};
        exp_o = q_def.pop_front();
        n_chk++;
        if (cur_def !== exp_o) begin
            n_err++;
            $display("FAIL sb_default: got %h expected %h", cur_def, exp_o);
        end
        exp_o = q_sml.pop_front();
        n_chk++;
        if (cur_sml !== exp_o) begin
            n_err++;
            $display("FAIL sb_small: got %h expected %h", cur_sml, exp_o);
        end
        exp_o = q_pol.pop_front();
        n_chk++;
        if (cur_pol !== exp_o) begin
            n_err++;
            $display("FAIL sb_polarity: got %h expected %h", cur_pol, exp_o);
        end
    endtask

    task automatic test_reset();
        obs_t rv;
        rv = {12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 13; i++) begin
            if (i < 3) cycle(1'b1, 1'b1);
            else       cycle(1'b0, 1'b0);
            n_chk++;
            if (cur_def !== rv) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, cur_def, rv);
            end
            n_chk++;
            if ({cur_pol.hs, cur_pol.vs} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_pol_idle cycle %0d: got %b expected 00", i, {cur_pol.hs, cur_pol.vs});
            end
        end
    endtask

    task automatic test_hsync_window();
        int fall, rise, low_cnt, le_cnt, le_col;
        logic prev_hs;
        fall = -1; rise = -1; low_cnt = 0; le_cnt = 0; le_col = -1;
        prev_hs = cur_def.hs;
        for (int i = 0; i < 1344; i++) begin
            cycle(1'b0, 1'b1);
            if (prev_hs && !cur_def.hs && fall < 0) fall = int'(cur_def.h);
            if (!prev_hs && cur_def.hs && rise < 0) rise = int'(cur_def.h);
            if (!cur_def.hs) low_cnt++;
            if (cur_def.le) begin le_cnt++; le_col = int'(cur_def.h); end
            prev_hs = cur_def.hs;
        end
        n_chk++;
        if (fall != 1048) begin n_err++; $display("FAIL hsync_fall: got %0d expected 1048", fall); end
        n_chk++;
        if (rise != 1184) begin n_err++; $display("FAIL hsync_rise: got %0d expected 1184", rise); end
        n_chk++;
        if (low_cnt != 136) begin n_err++; $display("FAIL hsync_width: got %0d expected 136", low_cnt); end
        n_chk++;
        if (le_cnt != 1 || le_col != 1343) begin
            n_err++;
            $display("FAIL line_end: got count %0d col %0d expected count 1 col 1343", le_cnt, le_col);
        end
        n_chk++;
        if (cur_def.h !== 12'd0 || cur_def.v !== 12'd1) begin
            n_err++;
            $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", cur_def.h, cur_def.v);
        end
    endtask

    task automatic test_frame_wrap();
        int vs_cnt, vmin, vmax, fe_cnt, fe_h, fe_v;
        vs_cnt = 0; vmin = 99; vmax = -1; fe_cnt = 0; fe_h = -1; fe_v = -1;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 127; i++) begin
            cycle(1'b0, 1'b1);
            if (!cur_sml.vs) begin
                vs_cnt++;
                if (int'(cur_sml.v) < vmin) vmin = int'(cur_sml.v);
                if (int'(cur_sml.v) > vmax) vmax = int'(cur_sml.v);
            end
            if (cur_sml.fe) begin fe_cnt++; fe_h = int'(cur_sml.h); fe_v = int'(cur_sml.v); end
        end
        n_chk++;
        if (vs_cnt != 32 || vmin != 5 || vmax != 6) begin
            n_err++;
            $display("FAIL vsync_window: got %0d cycles lines %0d..%0d expected 32 lines 5..6", vs_cnt, vmin, vmax);
        end
        n_chk++;
        if (fe_cnt != 1 || fe_h != 15 || fe_v != 7) begin
            n_err++;
            $display("FAIL frame_end: got count %0d at (%0d,%0d) expected 1 at (15,7)", fe_cnt, fe_h, fe_v);
        end
        cycle(1'b0, 1'b1);
        n_chk++;
        if (cur_sml.h !== 12'd0 || cur_sml.v !== 12'd0 || cur_sml.fc !== 8'd1) begin
            n_err++;
            $display("FAIL frame_wrap: got (%0d,%0d) fc %0d expected (0,0) fc 1", cur_sml.h, cur_sml.v, cur_sml.fc);
        end
    endtask

    task automatic test_frame_cnt_wrap();
        for (int i = 0; i < 254 * 128; i++) cycle(1'b0, 1'b1);
        n_chk++;
        if (cur_sml.fc !== 8'd255) begin
            n_err++;
            $display("FAIL frame_cnt_255: got %0d expected 255", cur_sml.fc);
        end
        for (int i = 0; i < 128; i++) cycle(1'b0, 1'b1);
        n_chk++;
        if (cur_sml.fc !== 8'd0 || cur_sml.h !== 12'd0 || cur_sml.v !== 12'd0) begin
            n_err++;
            $display("FAIL frame_cnt_wrap: got fc %0d at (%0d,%0d) expected fc 0 at (0,0)", cur_sml.fc, cur_sml.h, cur_sml.v);
        end
    endtask

    task automatic test_ce_gating();
        int start_pos, n_adv, guard, exp_fc;
        logic ce;
        start_pos = sv * 16 + sh;
        n_adv = 0;
        for (int i = 0; i < 400; i++) begin
            ce = 1'($urandom_range(0, 1));
            cycle(1'b0, ce);
            if (ce) n_adv++;
        end
        n_chk++;
        if (int'(cur_sml.v) * 16 + int'(cur_sml.h) != (start_pos + n_adv) % 128) begin
            n_err++;
            $display("FAIL ce_position: got %0d expected %0d", int'(cur_sml.v) * 16 + int'(cur_sml.h), (start_pos + n_adv) % 128);
        end
        guard = 0;
        while (!(sh == 15 && sv == 7) && guard < 200) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        exp_fc = (sfc + 1) % 256;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            n_chk++;
            if (cur_sml.fe !== 1'b1 || cur_sml.h !== 12'd15 || cur_sml.v !== 12'd7) begin
                n_err++;
                $display("FAIL ce_stall_at_wrap: got (%0d,%0d) fe %b expected (15,7) fe 1", cur_sml.h, cur_sml.v, cur_sml.fe);
            end
        end
        cycle(1'b0, 1'b1);
        n_chk++;
        if (cur_sml.h !== 12'd0 || cur_sml.v !== 12'd0 || cur_sml.fc !== 8'(exp_fc)) begin
            n_err++;
            $display("FAIL ce_wrap_resume: got (%0d,%0d) fc %0d expected (0,0) fc %0d", cur_sml.h, cur_sml.v, cur_sml.fc, exp_fc);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        obs_t rv;
        rv = {12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        guard = 0;
        while (!(sh == 10 && sv == 5) && guard < 200) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        n_chk++;
        if (cur_sml.h !== 12'd10 || cur_sml.v !== 12'd5 || cur_sml.hs !== 1'b0 || cur_sml.vs !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_setup: got (%0d,%0d) hs %b vs %b expected (10,5) hs 0 vs 0", cur_sml.h, cur_sml.v, cur_sml.hs, cur_sml.vs);
        end
        cycle(1'b1, 1'b1);
        n_chk++;
        if (cur_sml !== rv) begin
            n_err++;
            $display("FAIL mid_reset_values: got %h expected %h", cur_sml, rv);
        end
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 1'b1);
            n_chk++;
            if (cur_sml.h !== 12'(k) || cur_sml.v !== 12'd0) begin
                n_err++;
                $display("FAIL mid_reset_restart: got (%0d,%0d) expected (%0d,0)", cur_sml.h, cur_sml.v, k);
            end
        end
    endtask

    task automatic test_polarity();
        int hs_hi, vs_hi;
        hs_hi = 0; vs_hi = 0;
        cycle(1'b1, 1'b1);
        n_chk++;
        if ({cur_pol.hs, cur_pol.vs} !== 2'b00) begin
            n_err++;
            $display("FAIL pol_idle: got %b expected 00", {cur_pol.hs, cur_pol.vs});
        end
        for (int i = 0; i < 128; i++) begin
            cycle(1'b0, 1'b1);
            if (cur_pol.hs) hs_hi++;
            if (cur_pol.vs) vs_hi++;
        end
        n_chk++;
        if (hs_hi != 24 || vs_hi != 32) begin
            n_err++;
            $display("FAIL pol_active: got hs %0d vs %0d expected hs 24 vs 32", hs_hi, vs_hi);
        end
    endtask

    initial begin
        if_def.CE = 1'b1;
        if_sml.CE = 1'b1;
        if_pol.CE = 1'b1;
        test_reset();
        test_hsync_window();
        test_frame_wrap();
        test_frame_cnt_wrap();
        test_ce_gating();
        test_reset_mid();
        test_polarity();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
